// File: rtl/basic_gate_pkg.sv
// basic_gate_pkg: shared width default and per-lane gate result type for basic_gate_unit.
// Optional inverted outputs (nand/nor/xnor) are included when BASIC_GATE_UNIT_INV_EN is defined.
package basic_gate_pkg;
    localparam int BGU_DEFAULT_WIDTH = 2;
    typedef struct packed {
        logic g_and;
        logic g_or;
        logic g_xor;
`ifdef BASIC_GATE_UNIT_INV_EN
        logic g_nand;
        logic g_nor;
        logic g_xnor;
`endif
    } lane_t;
endpackage

// File: rtl/basic_gate_unit_gate_lane.sv
// gate_lane: combinational single-bit cell producing all gate results for one lane.
// Ports: a, b (lane operands) -> r (lane_t gate results).
// Inverted results are present when BASIC_GATE_UNIT_INV_EN is defined.
module gate_lane
    import basic_gate_pkg::*;
(
    input  logic  a,
    input  logic  b,
    output lane_t r
);
    always_comb begin
        r.g_and  = a & b;
        r.g_or   = a | b;
        r.g_xor  = a ^ b;
`ifdef BASIC_GATE_UNIT_INV_EN
        r.g_nand = ~(a & b);
        r.g_nor  = ~(a | b);
        r.g_xnor = ~(a ^ b);
`endif
    end
endmodule

// File: rtl/basic_gate_unit.sv
// basic_gate_unit: registered bitwise AND/OR/XOR unit with valid qualifier and one-cycle latency.
// Ports: clk, rst_n (async active-low), in_valid, a, b -> out_valid, c_and, c_or, c_xor.
// BASIC_GATE_UNIT_INV_EN adds registered c_nand, c_nor, c_xnor (reset to zero).
// Results hold when in_valid is low; only out_valid drops.
module basic_gate_unit
    import basic_gate_pkg::*;
#(
    parameter int WIDTH = BGU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] c_and,
    output logic [WIDTH-1:0] c_or,
    output logic [WIDTH-1:0] c_xor
`ifdef BASIC_GATE_UNIT_INV_EN
    ,
    output logic [WIDTH-1:0] c_nand,
    output logic [WIDTH-1:0] c_nor,
    output logic [WIDTH-1:0] c_xnor
`endif
);
    lane_t            lane_r [WIDTH];
    logic [WIDTH-1:0] and_d, or_d, xor_d;
`ifdef BASIC_GATE_UNIT_INV_EN
    logic [WIDTH-1:0] nand_d, nor_d, xnor_d;
`endif

    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_lane
        gate_lane u_lane (
            .a (a[i]),
            .b (b[i]),
            .r (lane_r[i])
        );
        assign and_d[i]  = lane_r[i].g_and;
        assign or_d[i]   = lane_r[i].g_or;
        assign xor_d[i]  = lane_r[i].g_xor;
`ifdef BASIC_GATE_UNIT_INV_EN
        assign nand_d[i] = lane_r[i].g_nand;
        assign nor_d[i]  = lane_r[i].g_nor;
        assign xnor_d[i] = lane_r[i].g_xnor;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c_and     <= '0;
            c_or      <= '0;
            c_xor     <= '0;
`ifdef BASIC_GATE_UNIT_INV_EN
            c_nand    <= '0;
            c_nor     <= '0;
            c_xnor    <= '0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c_and  <= and_d;
                c_or   <= or_d;
                c_xor  <= xor_d;
`ifdef BASIC_GATE_UNIT_INV_EN
                c_nand <= nand_d;
                c_nor  <= nor_d;
                c_xnor <= xnor_d;
`endif
            end
        end
    end
endmodule

// File: tb/tb_basic_gate_unit.sv
// tb_basic_gate_unit: directed self-checking bench for basic_gate_unit at WIDTH=2 and WIDTH=1.
module tb_basic_gate_unit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_valid1;
    logic [1:0] a, b;
    logic       a1, b1;
    logic       out_valid, out_valid1;
    logic [1:0] c_and, c_or, c_xor;
    logic       c_and1, c_or1, c_xor1;
`ifdef BASIC_GATE_UNIT_INV_EN
    logic [1:0] c_nand, c_nor, c_xnor;
    logic       c_nand1, c_nor1, c_xnor1;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    basic_gate_unit #(.WIDTH(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c_and     (c_and),
        .c_or      (c_or),
        .c_xor     (c_xor)
`ifdef BASIC_GATE_UNIT_INV_EN
        ,
        .c_nand    (c_nand),
        .c_nor     (c_nor),
        .c_xnor    (c_xnor)
`endif
    );

    basic_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .out_valid (out_valid1),
        .c_and     (c_and1),
        .c_or      (c_or1),
        .c_xor     (c_xor1)
`ifdef BASIC_GATE_UNIT_INV_EN
        ,
        .c_nand    (c_nand1),
        .c_nor     (c_nor1),
        .c_xnor    (c_xnor1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w2(input string tag, input logic v, input logic [1:0] e_and, input logic [1:0] e_or, input logic [1:0] e_xor);
        chk({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
        chk({tag, "_and"}, {62'd0, c_and}, {62'd0, e_and});
        chk({tag, "_or"}, {62'd0, c_or}, {62'd0, e_or});
        chk({tag, "_xor"}, {62'd0, c_xor}, {62'd0, e_xor});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = 2'b11; b = 2'b11;
        in_valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        repeat (3) tick();
        chk_w2("rst_hold", 1'b0, 2'b00, 2'b00, 2'b00);
        chk("rst_hold_w1", {61'd0, out_valid1, c_and1, c_or1}, 64'd0);
`ifdef BASIC_GATE_UNIT_INV_EN
        chk("rst_hold_inv", {58'd0, c_nand, c_nor, c_xnor}, 64'd0);
`endif
        rst_n = 1'b1; in_valid1 = 1'b0;
        a = 2'b01; b = 2'b11;
        tick();
        chk_w2("vec1", 1'b1, 2'b01, 2'b11, 2'b10);
`ifdef BASIC_GATE_UNIT_INV_EN
        chk("vec1_nand", {62'd0, c_nand}, 64'd2);
        chk("vec1_nor", {62'd0, c_nor}, 64'd0);
        chk("vec1_xnor", {62'd0, c_xnor}, 64'd1);
`endif
        a = 2'b10; b = 2'b10;
        tick();
        chk_w2("vec2", 1'b1, 2'b10, 2'b10, 2'b00);
        a = 2'b11; b = 2'b01;
        tick();
        chk_w2("cap", 1'b1, 2'b01, 2'b11, 2'b10);
        in_valid = 1'b0; a = 2'b00; b = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_w2("hold", 1'b0, 2'b01, 2'b11, 2'b10);
        end
        a = 2'bxx; b = 2'bxx;
        tick();
        chk_w2("hold_x", 1'b0, 2'b01, 2'b11, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk_w2("async_rst", 1'b0, 2'b00, 2'b00, 2'b00);
        #2 rst_n = 1'b1;
        in_valid1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0];
            tick();
            chk($sformatf("tt%0d_valid", i), {63'd0, out_valid1}, 64'd1);
            chk($sformatf("tt%0d_and", i), {63'd0, c_and1}, {63'd0, i == 3});
            chk($sformatf("tt%0d_or", i), {63'd0, c_or1}, {63'd0, i != 0});
            chk($sformatf("tt%0d_xor", i), {63'd0, c_xor1}, {63'd0, i == 1 || i == 2});
        end
        in_valid1 = 1'b0;
        in_valid = 1'b1; a = 2'b11; b = 2'b10;
        tick();
        chk_w2("stream1", 1'b1, 2'b10, 2'b11, 2'b01);
        a = 2'b01; b = 2'b01;
        tick();
        chk_w2("stream2", 1'b1, 2'b01, 2'b01, 2'b00);
        rst_n = 1'b0;
        #1;
        chk_w2("mid_rst", 1'b0, 2'b00, 2'b00, 2'b00);
        #3 rst_n = 1'b1; in_valid = 1'b0; a = 2'b11; b = 2'b11;
        tick();
        chk_w2("post_rst_idle", 1'b0, 2'b00, 2'b00, 2'b00);
        in_valid = 1'b1;
        tick();
        chk_w2("post_rst_cap", 1'b1, 2'b11, 2'b11, 2'b00);
        in_valid = 1'b0;
        tick();
        chk_w2("post_rst_drop", 1'b0, 2'b11, 2'b11, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
